rv4028_bus_arbiter: RTL
=======================

Name: rv4028_bus_arbiter

Overview:
- Shares the RV4028 external bus between the CPU (default owner) and up to NUM_MASTERS external bus masters (DMA, debug loader).
- Requests the bus from the CPU through busrq_n/busack_n, then grants it to one master at a time using round-robin order.
- Enforces a maximum tenure per grant and a turnaround gap.
- Returns the bus to the CPU after every master tenure so the CPU cannot be starved.

Parameters:
- NUM_MASTERS, 2, number of external requesters (1..4).
- MAX_HOLD, 256, cycles a master may hold a grant before preempt is raised; 0 disables the limit.
- TURNAROUND, 1, idle cycles after a master releases before busrq_n is deasserted (bus float time).
- HOLD_W, 9, tenure counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk, input, 1, system clock; same clock as the CPU core.
- rst, input, 1, asynchronous active-high reset.
- busack_n, input, 1, CPU bus release acknowledge; low means the CPU has tri-stated addr/control.
- busrq_n, output, 1, bus request to the CPU; active low.
- mreq, input, NUM_MASTERS, per-master bus request; level, active high.
- mgnt, output, NUM_MASTERS, per-master grant; one-hot or zero.
- preempt, output, 1, tenure limit reached; the current master must drop mreq.
- owner, output, 2, index of the granted master; valid while any mgnt bit is high.
- err, output, 1, sticky: busack_n rose while a master held a grant.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- busack_n is sampled synchronously; no synchronizer is needed.
- Reset values: busrq_n=1, mgnt=0, preempt=0, owner=0, err=0, state=IDLE, rr_ptr=0, tenure counter=0.
- All outputs are registered.
- State machine:
  - IDLE: CPU owns the bus. If any mreq bit is high, go to REQ and drive busrq_n=0 on the next cycle.
  - REQ: hold busrq_n=0 until busack_n=0 is sampled. Then pick the winner: first set mreq bit at or after rr_ptr, wrapping modulo NUM_MASTERS. Go to GRANT; mgnt[winner]=1 and owner=winner on the next cycle.
    - If all mreq bits are low when busack_n arrives, go to RETURN without granting.
  - GRANT: mgnt is held; the tenure counter increments every cycle from 0.
    - When the counter reaches MAX_HOLD-1 (MAX_HOLD>0), preempt=1 and stays high until release.
    - The master releases by dropping its mreq. mgnt clears on the next cycle, preempt clears with it, and rr_ptr=winner+1 modulo NUM_MASTERS. Go to GAP.
    - Arbitration is non-preemptive: a master ignoring preempt keeps the grant. preempt is advisory only.
  - GAP: count TURNAROUND cycles with busrq_n still 0, then go to RETURN. TURNAROUND=0 goes to RETURN immediately.
  - RETURN: drive busrq_n=1 and wait for busack_n=1. Then go to IDLE.
    - IDLE must spend at least one cycle before re-requesting, which guarantees the CPU one bus slot between tenures.
- Latency, uncontended case:
  - mreq rise to busrq_n fall: 1 cycle.
  - busack_n fall to mgnt rise: 1 cycle.
  - mreq fall to mgnt fall: 1 cycle.
- A master whose mreq drops while in REQ loses its place. Arbitration uses mreq as sampled on the busack_n cycle.
- Requests from the CPU side (busack_n) are never reordered. The CPU finishes its in-flight transaction before asserting busack_n; the arbiter does not monitor req_n.
- Protocol error: busack_n sampled high while in GRANT means:
  - err=1 (sticky until rst) and mgnt cleared the next cycle;
  - go to RETURN.
- Simultaneous requests: only one mgnt bit is ever high. Round-robin guarantees each requester a grant within NUM_MASTERS tenures.
- Reset asserted mid-tenure:
  - mgnt and busrq_n return to their reset values immediately (asynchronous).
  - The master must treat loss of mgnt as abort.
- The tenure counter saturates at its maximum value; it never wraps.

Test Plan:
- Single request: mreq=01, busack_n follows busrq_n after 3 cycles → busrq_n low 1 cycle after mreq; mgnt=01 and owner=0 1 cycle after busack_n low; mreq drop → mgnt=00 next cycle, busrq_n high after TURNAROUND=1, IDLE after busack_n high.
- Round-robin: mreq=11 held continuously → grants alternate 01,10,01,10. Each tenure is separated by busrq_n high and at least one IDLE cycle with busack_n high.
- Tenure limit (MAX_HOLD=4): master holds mreq → preempt rises on the 4th GRANT cycle and stays high. Grant is kept until mreq drops, then preempt=0 and mgnt=0 on the same cycle.
- Request withdrawn: mreq pulses high for 1 cycle, drops before busack_n → no mgnt asserted; busrq_n returns high; state returns to IDLE.
- Protocol error: busack_n forced high during GRANT → err=1, mgnt=0 next cycle. err stays 1 across further transactions until rst.
- Async reset mid-GRANT: rst pulsed between clock edges → mgnt=0, busrq_n=1, preempt=0 before the next edge. After release, a fresh request proceeds normally from rr_ptr=0.

Source files
------------

// File: rtl/rv4028_bus_arbiter_if.sv
// Bus-sharing signals between the RV4028 CPU, the external masters and the arbiter.
// Handshake: mreq is a level request held for the whole tenure. mgnt (one-hot or zero)
// stays high until the master drops mreq. busrq_n/busack_n are the CPU's low-active
// request/acknowledge pair; busack_n low means the CPU has released the bus.
interface rv4028_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic                   busack_n;
  logic                   busrq_n;
  logic [NUM_MASTERS-1:0] mreq;
  logic [NUM_MASTERS-1:0] mgnt;
  logic                   preempt;
  logic [1:0]             owner;
  logic                   err;

  // master: the arbiter, which owns grant/request generation.
  modport master (
    input  busack_n, mreq,
    output busrq_n, mgnt, preempt, owner, err
  );

  // slave: the CPU and the requesting masters.
  modport slave (
    output busack_n, mreq,
    input  busrq_n, mgnt, preempt, owner, err
  );
endinterface

// File: rtl/rv4028_bus_arbiter.sv
// Round-robin arbiter lending the RV4028 bus from the CPU to external masters,
// with a tenure limit, turnaround gap and a mandatory CPU slot between tenures.
module rv4028_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 256,
  parameter int TURNAROUND  = 1,
  parameter int HOLD_W      = 9
) (
  input  logic                clk,
  input  logic                rst,
  rv4028_bus_arbiter_if.master bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_GRANT  = 3'd2,
    S_GAP    = 3'd3,
    S_RETURN = 3'd4
  } state_t;

  localparam int GAP_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam bit HOLD_ON = (MAX_HOLD > 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t                 state, state_nx;
  logic                   busrq_n_q, busrq_n_nx;
  logic [NUM_MASTERS-1:0] mgnt_q, mgnt_nx;
  logic                   preempt_q, preempt_nx;
  logic [1:0]             owner_q, owner_nx;
  logic                   err_q, err_nx;
  logic [1:0]             rr_ptr, rr_nx;
  logic [HOLD_W-1:0]      hold_cnt, hold_nx;
  logic [GAP_W-1:0]       gap_cnt, gap_nx;

  logic [3:0] req4;
  logic [2:0] idx;
  logic [1:0] winner;
  logic       found;

  function automatic logic [1:0] rr_next(input logic [1:0] w);
    logic [2:0] n;
    n = {1'b0, w} + 3'd1;
    if (n >= 3'(NUM_MASTERS)) n = 3'd0;
    return n[1:0];
  endfunction

  // Winner: first requesting master at or after rr_ptr, wrapping modulo NUM_MASTERS.
  always_comb begin
    req4   = 4'(bus.mreq);
    idx    = 3'd0;
    winner = rr_ptr;
    found  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = {1'b0, rr_ptr} + 3'(i);
      if (idx >= 3'(NUM_MASTERS)) idx = idx - 3'(NUM_MASTERS);
      if (!found && req4[idx[1:0]]) begin
        found  = 1'b1;
        winner = idx[1:0];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    busrq_n_nx = busrq_n_q;
    mgnt_nx    = mgnt_q;
    preempt_nx = preempt_q;
    owner_nx   = owner_q;
    err_nx     = err_q;
    rr_nx      = rr_ptr;
    hold_nx    = hold_cnt;
    gap_nx     = gap_cnt;
    case (state)
      S_IDLE: begin
        busrq_n_nx = 1'b1;
        if (|bus.mreq) begin
          state_nx   = S_REQ;
          busrq_n_nx = 1'b0;
        end
      end
      S_REQ: begin
        if (!bus.busack_n) begin
          if (found) begin
            state_nx   = S_GRANT;
            mgnt_nx    = NUM_MASTERS'(4'b0001 << winner);
            owner_nx   = winner;
            hold_nx    = '0;
            preempt_nx = HOLD_ON && (HOLD_LIM == '0);
          end else begin
            state_nx   = S_RETURN;
            busrq_n_nx = 1'b1;
          end
        end
      end
      S_GRANT: begin
        if (bus.busack_n) begin
          // CPU took the bus back under a live grant: abort the tenure.
          state_nx   = S_RETURN;
          err_nx     = 1'b1;
          mgnt_nx    = '0;
          preempt_nx = 1'b0;
          busrq_n_nx = 1'b1;
          hold_nx    = '0;
          rr_nx      = rr_next(owner_q);
        end else if (!req4[owner_q]) begin
          mgnt_nx    = '0;
          preempt_nx = 1'b0;
          hold_nx    = '0;
          rr_nx      = rr_next(owner_q);
          if (TURNAROUND == 0) begin
            state_nx   = S_RETURN;
            busrq_n_nx = 1'b1;
          end else begin
            state_nx = S_GAP;
            gap_nx   = '0;
          end
        end else begin
          if (hold_cnt != '1) hold_nx = hold_cnt + 1'b1;
          preempt_nx = HOLD_ON && (hold_nx >= HOLD_LIM);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(TURNAROUND - 1)) begin
          state_nx   = S_RETURN;
          busrq_n_nx = 1'b1;
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      S_RETURN: begin
        busrq_n_nx = 1'b1;
        if (bus.busack_n) state_nx = S_IDLE;
      end
      default: begin
        state_nx   = S_IDLE;
        busrq_n_nx = 1'b1;
        mgnt_nx    = '0;
        preempt_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busrq_n_q <= 1'b1;
      mgnt_q    <= '0;
      preempt_q <= 1'b0;
      owner_q   <= 2'd0;
      err_q     <= 1'b0;
      rr_ptr    <= 2'd0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nx;
      busrq_n_q <= busrq_n_nx;
      mgnt_q    <= mgnt_nx;
      preempt_q <= preempt_nx;
      owner_q   <= owner_nx;
      err_q     <= err_nx;
      rr_ptr    <= rr_nx;
      hold_cnt  <= hold_nx;
      gap_cnt   <= gap_nx;
    end
  end

  assign bus.busrq_n = busrq_n_q;
  assign bus.mgnt    = mgnt_q;
  assign bus.preempt = preempt_q;
  assign bus.owner   = owner_q;
  assign bus.err     = err_q;
  assign dbg_state   = state;

endmodule
